// File: rtl/execute_muldiv_pkg.sv
// Shared constants for the execute-stage M-extension unit: funct3 encodings, FSM states, default width.
package execute_muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/execute_muldiv_iter.sv
// Bit-serial datapath: unsigned shift-add multiply or restoring divide, one step per strobe.
// step_hi/step_lo are the register values after the pending step, so the caller can capture the final result.
module execute_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] step_hi,
    output logic [XLEN-1:0] step_lo
);

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;
    logic            div_q;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Multiply: lo holds the remaining multiplier bits, product shifts in from the top.
    // Divide: lo holds the dividend shifting out and the quotient shifting in; hi is the partial remainder.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        step_hi = sum[XLEN:1];
        step_lo = {sum[0], lo_q[XLEN-1:1]};
        if (div_q) begin
            if (diff[XLEN]) begin
                step_hi = shifted[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                step_hi = diff[XLEN-1:0];
                step_lo = {lo_q[XLEN-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi_q  <= '0;
            lo_q  <= op_a;
            b_q   <= op_b;
            div_q <= is_div;
        end else if (step) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
        end
    end

endmodule

// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide beside the ALU; stalls execute while iterating.
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiplier for MUL*.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            phase_execute,
    input  logic            md_valid,
    input  logic [2:0]      funct3_md,
    input  logic [XLEN-1:0] rs1data_de,
    input  logic [XLEN-1:0] rs2data_de,
    output logic [XLEN-1:0] md_result,
    output logic            md_done,
    output logic            md_busy,
    output logic            stall_execute
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic             neg_q;

    logic             start;
    logic             s1_signed, s2_signed;
    logic             neg1, neg2;
    logic [XLEN-1:0]  mag1, mag2;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  special_res;
    logic             fast_hit;
    logic [XLEN-1:0]  fast_res;
    logic             iter_load, iter_step;
    logic [XLEN-1:0]  step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_n;
    logic [XLEN-1:0]  div_sel, div_n, calc_res;

    assign start = (state == MD_IDLE) & phase_execute & md_valid;

    always_comb begin
        s1_signed = 1'b0;
        s2_signed = 1'b0;
        case (funct3_md)
            FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM: begin
                s1_signed = 1'b1;
                s2_signed = 1'b1;
            end
            FUNCT3_MULHSU:                       s1_signed = 1'b1;
            FUNCT3_MUL, FUNCT3_MULHU,
            FUNCT3_DIVU, FUNCT3_REMU:            s1_signed = 1'b0;
            default:                             s1_signed = 1'b0;
        endcase
    end

    assign neg1 = s1_signed & rs1data_de[XLEN-1];
    assign neg2 = s2_signed & rs2data_de[XLEN-1];
    assign mag1 = neg1 ? ('0 - rs1data_de) : rs1data_de;
    assign mag2 = neg2 ? ('0 - rs2data_de) : rs2data_de;

    // Only signed DIV/REM (funct3[0]==0) can overflow.
    assign div_zero = funct3_md[2] & (rs2data_de == '0);
    assign div_ovf  = funct3_md[2] & ~funct3_md[0] & (rs1data_de == INT_MIN) & (rs2data_de == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        if (div_zero) special_res = funct3_md[1] ? rs1data_de : '1;
        else          special_res = funct3_md[1] ? '0 : rs1data_de;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    always_comb begin
        ext_a     = {{XLEN{s1_signed & rs1data_de[XLEN-1]}}, rs1data_de};
        ext_b     = {{XLEN{s2_signed & rs2data_de[XLEN-1]}}, rs2data_de};
        fast_prod = ext_a * ext_b;
        fast_hit  = ~funct3_md[2];
        fast_res  = (funct3_md == FUNCT3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    always_comb begin
        state_nxt     = state;
        iter_load     = 1'b0;
        iter_step     = 1'b0;
        stall_execute = 1'b0;
        md_busy       = 1'b0;
        md_done       = 1'b0;
        case (state)
            MD_IDLE: begin
                stall_execute = phase_execute & md_valid;
                if (start) begin
                    if (special | fast_hit) begin
                        state_nxt = MD_DONE;
                    end else begin
                        state_nxt = MD_CALC;
                        iter_load = 1'b1;
                    end
                end
            end
            MD_CALC: begin
                stall_execute = 1'b1;
                md_busy       = 1'b1;
                iter_step     = 1'b1;
                if (cnt == '0) state_nxt = MD_DONE;
            end
            MD_DONE: begin
                md_busy   = 1'b1;
                md_done   = 1'b1;
                state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    execute_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (iter_load),
        .step    (iter_step),
        .is_div  (funct3_md[2]),
        .op_a    (mag1),
        .op_b    (mag2),
        .step_hi (step_hi),
        .step_lo (step_lo)
    );

    // Sign fix-up applied to the full 2*XLEN product so MULH* high words come out right.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_n   = neg_q ? ('0 - prod) : prod;
        div_sel  = op_q[1] ? step_hi : step_lo;
        div_n    = neg_q ? ('0 - div_sel) : div_sel;
        if (op_q[2])                 calc_res = div_n;
        else if (op_q == FUNCT3_MUL) calc_res = prod_n[XLEN-1:0];
        else                         calc_res = prod_n[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            md_result <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                op_q  <= funct3_md;
                neg_q <= (funct3_md[2] & funct3_md[1]) ? neg1 : (neg1 ^ neg2);
                cnt   <= CNT_W'(XLEN - 1);
                if (special)       md_result <= special_res;
                else if (fast_hit) md_result <= fast_res;
            end else if (state == MD_CALC) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == '0) md_result <= calc_res;
            end
        end
    end

endmodule
